bounce_mon: RTL and testbench
=============================

BOUNCE_MON -- requirements
Module: bounce_mon

Interface
REQ-001 SHALL have parameter LOCK_STEPS, default 3: consecutive legal steps required before locked asserts (range 1..15).
REQ-002 SHALL have parameter SW_W, default 8: width of sweep_cnt.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port cnt_in  input  3  sample from the upstream 0..6 bouncing up/down counter.
REQ-006 SHALL have port cnt_vld  input  1  qualifies cnt_in; the sample is ignored when low.
REQ-007 SHALL have port dir  output  1  tracked direction: 0 = UP, 1 = DOWN.
REQ-008 SHALL have port peak  output  1  one-cycle pulse on a legal 6->5 turn.
REQ-009 SHALL have port valley  output  1  one-cycle pulse on a legal 1->2 turn.
REQ-010 SHALL have port err  output  1  one-cycle pulse on an illegal step.
REQ-011 SHALL have port locked  output  1  high while the stream is tracked legally.
REQ-012 SHALL have port sweep_cnt  output  SW_W  count of valleys seen since reset.

Function
REQ-013 SHALL use FSM states IDLE (no previous sample), ACQ (previous sample held, direction unknown), UP and DOWN; a prev register holds the last valid sample.
REQ-014 SHALL hold all state and outputs, except that pulse outputs clear, in cycles where cnt_vld=0.
REQ-015 SHALL make every output a register, updated one cycle after the qualifying sample, with latency 1.
REQ-016 In IDLE, a valid sample SHALL load prev, flag no error and move to ACQ, unless the sample is 7, in which case err pulses and the FSM stays in IDLE.
REQ-017 In ACQ, the step next=prev+1 with prev in 0..5 SHALL go to UP, and next=prev-1 with prev in 2..6 SHALL go to DOWN; any other sample SHALL pulse err and stay in ACQ.
REQ-018 In UP, the step prev+1 for prev<6 SHALL be legal and keep UP; for prev=6 the only legal sample is 5, which SHALL go to DOWN and pulse peak.
REQ-019 In DOWN, the step prev-1 for prev>1 SHALL be legal and keep DOWN; for prev=1 the only legal sample is 2, which SHALL go to UP, pulse valley and increment sweep_cnt.
REQ-020 In UP or DOWN, any other sample (including 0, 7 and a repeated value) SHALL pulse err, clear locked, clear the legal-step count and move to ACQ.
REQ-021 On every valid sample, prev SHALL load cnt_in, including on an error, except when cnt_in=7.
REQ-022 A saturating legal-step counter SHALL increment on each legal step; locked SHALL assert in the cycle after the count reaches LOCK_STEPS.
REQ-023 sweep_cnt SHALL wrap from all-ones to 0.
REQ-024 err and peak/valley SHALL be mutually exclusive in any cycle.
REQ-025 dir SHALL be 0 in IDLE/ACQ/UP and 1 in DOWN.

Reset
REQ-026 On rst=1, the block SHALL immediately set the FSM to IDLE and clear prev, the legal-step count, dir, peak, valley, err, locked and sweep_cnt to 0, regardless of clk.
REQ-027 The first valid sample after rst deasserts SHALL be handled as the IDLE case.

Configuration
REQ-028 With macro BOUNCE_MON_ERR_CNT_EN defined, the block SHALL add port err_cnt  output  8, which increments once per err pulse, saturates at 255, and resets to 0.
REQ-029 Without BOUNCE_MON_ERR_CNT_EN, err_cnt and its register SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-030 The bench SHALL cover a legal sweep: rst, then valid 0,1,2,3,4,5,6,5,4,3,2,1,2 -> locked=1 from the cycle after sample 3, peak one cycle after sample 5 (post-6), valley one cycle after the final 2, sweep_cnt=1, no err.
REQ-031 The bench SHALL cover an illegal value: while locked in UP at prev=4, sample 7 -> err=1 for one cycle, locked=0, FSM ACQ, prev stays 4.
REQ-032 The bench SHALL cover a stall: while locked, sample 3 then 3 -> err pulse, locked drops; the next samples 4,5,6 -> locked reasserts after 3 legal steps.
REQ-033 The bench SHALL cover qualifier gaps: a legal sweep with cnt_vld low on alternate cycles and garbage on cnt_in -> identical pulse sequence, no err.
REQ-034 The bench SHALL cover wrap and reset: 256 full sweeps -> sweep_cnt returns to 0; rst asserted mid-sweep between clock edges -> all outputs 0 immediately.
REQ-035 The bench SHALL cover the configured counter: with BOUNCE_MON_ERR_CNT_EN defined, 300 consecutive value-7 samples -> err_cnt=255 and holds.

Source files
------------

// File: rtl/bounce_mon_if.sv
// Sample and status bundle for bounce_mon. Declares err_cnt only when
// BOUNCE_MON_ERR_CNT_EN is defined.
interface bounce_mon_if #(
    parameter int SW_W = 8
);
    logic [2:0]      cnt_in;
    logic            cnt_vld;
    logic            dir;
    logic            peak;
    logic            valley;
    logic            err;
    logic            locked;
    logic [SW_W-1:0] sweep_cnt;
`ifdef BOUNCE_MON_ERR_CNT_EN
    logic [7:0]      err_cnt;
`endif

    // Upstream side: drives samples and observes the tracking status.
    modport master (
        output cnt_in,
        output cnt_vld,
        input  dir,
        input  peak,
        input  valley,
        input  err,
        input  locked,
        input  sweep_cnt
`ifdef BOUNCE_MON_ERR_CNT_EN
        , input err_cnt
`endif
    );

    modport slave (
        input  cnt_in,
        input  cnt_vld,
        output dir,
        output peak,
        output valley,
        output err,
        output locked,
        output sweep_cnt
`ifdef BOUNCE_MON_ERR_CNT_EN
        , output err_cnt
`endif
    );
endinterface

// File: rtl/bounce_mon.sv
// Tracks a 0..6 bouncing up/down counter, flags turns and illegal steps.
// Define BOUNCE_MON_ERR_CNT_EN to add the saturating err_cnt output.
module bounce_mon #(
    parameter int LOCK_STEPS = 3,
    parameter int SW_W       = 8
) (
    input logic         clk,
    input logic         rst,
    bounce_mon_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACQ, UP, DOWN} state_t;

    localparam logic [3:0] LOCK_LIM = 4'(LOCK_STEPS);

    state_t          state_q, state_d;
    logic [2:0]      prev_q, prev_d;
    logic [3:0]      step_q, step_d;
    logic            dir_q, dir_d;
    logic            peak_q, peak_d;
    logic            valley_q, valley_d;
    logic            err_q, err_d;
    logic            locked_q, locked_d;
    logic [SW_W-1:0] sweep_q, sweep_d;
    logic [2:0]      prevInc, prevDec;
    logic            legal;
`ifdef BOUNCE_MON_ERR_CNT_EN
    logic [7:0]      err_cnt_q, err_cnt_d;
`endif

    assign prevInc = prev_q + 3'd1;
    assign prevDec = prev_q - 3'd1;

    // Classify each qualified sample against the tracked state; a 7 never
    // enters prev, so prevInc/prevDec never wrap on a value we could hold.
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        step_d   = step_q;
        dir_d    = dir_q;
        locked_d = locked_q;
        sweep_d  = sweep_q;
        peak_d   = 1'b0;
        valley_d = 1'b0;
        err_d    = 1'b0;
        legal    = 1'b0;
        if (bus.cnt_vld) begin
            if (bus.cnt_in != 3'd7) begin
                prev_d = bus.cnt_in;
            end
            case (state_q)
                IDLE: begin
                    if (bus.cnt_in == 3'd7) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ACQ;
                    end
                end
                ACQ: begin
                    if (prev_q <= 3'd5 && bus.cnt_in == prevInc) begin
                        state_d = UP;
                        legal   = 1'b1;
                    end else if (prev_q >= 3'd2 && bus.cnt_in == prevDec) begin
                        state_d = DOWN;
                        legal   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                UP: begin
                    if (prev_q < 3'd6 && bus.cnt_in == prevInc) begin
                        legal = 1'b1;
                    end else if (prev_q == 3'd6 && bus.cnt_in == 3'd5) begin
                        legal   = 1'b1;
                        peak_d  = 1'b1;
                        state_d = DOWN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ACQ;
                    end
                end
                DOWN: begin
                    if (prev_q > 3'd1 && bus.cnt_in == prevDec) begin
                        legal = 1'b1;
                    end else if (prev_q == 3'd1 && bus.cnt_in == 3'd2) begin
                        legal    = 1'b1;
                        valley_d = 1'b1;
                        sweep_d  = sweep_q + SW_W'(1);
                        state_d  = UP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ACQ;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (err_d) begin
                step_d = 4'd0;
            end else if (legal && step_q < LOCK_LIM) begin
                step_d = step_q + 4'd1;
            end
            locked_d = (step_d >= LOCK_LIM);
            dir_d    = (state_d == DOWN);
        end
    end

`ifdef BOUNCE_MON_ERR_CNT_EN
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`endif

    // Tracking state and every output live here, so outputs lag the sample by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            prev_q   <= 3'd0;
            step_q   <= 4'd0;
            dir_q    <= 1'b0;
            peak_q   <= 1'b0;
            valley_q <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            sweep_q  <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            peak_q   <= peak_d;
            valley_q <= valley_d;
            err_q    <= err_d;
            locked_q <= locked_d;
            sweep_q  <= sweep_d;
        end
    end

    assign bus.dir       = dir_q;
    assign bus.peak      = peak_q;
    assign bus.valley    = valley_q;
    assign bus.err       = err_q;
    assign bus.locked    = locked_q;
    assign bus.sweep_cnt = sweep_q;
endmodule

// File: tb/tb_bounce_mon.sv
// Directed self-checking bench for bounce_mon; expected status vectors are
// hand-computed as {dir, peak, valley, err, locked} plus sweep_cnt.
module tb_bounce_mon;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    bounce_mon_if #(.SW_W(8)) bus ();

    bounce_mon #(.LOCK_STEPS(3), .SW_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Last-resort guard so a broken design can never hang the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic vld, input logic [2:0] val);
        @(negedge clk);
        bus.cnt_vld = vld;
        bus.cnt_in  = val;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [4:0] e5, input logic [7:0] eSw);
        logic [12:0] obs;
        obs = {bus.dir, bus.peak, bus.valley, bus.err, bus.locked, bus.sweep_cnt};
        total++;
        assert (obs === {e5, eSw}) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, {e5, eSw});
        end
    endtask

`ifdef BOUNCE_MON_ERR_CNT_EN
    task automatic checkErrCnt(input string tag, input logic [7:0] eCnt, input logic eErr);
        total++;
        assert ({bus.err_cnt, bus.err} === {eCnt, eErr}) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d/%b expected=%0d/%b", tag, bus.err_cnt, bus.err, eCnt, eErr);
        end
    endtask
`endif

    task automatic resetDut();
        bus.cnt_vld = 1'b0;
        bus.cnt_in  = 3'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [2:0] seqA [0:12];
        logic [4:0] expA [0:12];
        logic [2:0] wrapSeq [0:9];
        logic [4:0] lastExp;
        logic [7:0] lastSw;
        logic [7:0] eSw;

        total = 0;
        bad   = 0;
        seqA    = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd2};
        expA    = '{5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00001, 5'b00001, 5'b00001,
                    5'b11001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b00101};
        wrapSeq = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd2};

        resetDut();
        checkOutput("reset", 5'b00000, 8'd0);

        // IDLE and ACQ error handling
        applyStimulus(1'b1, 3'd7);
        checkOutput("idle7", 5'b00010, 8'd0);
        applyStimulus(1'b0, 3'd3);
        checkOutput("idleGap", 5'b00000, 8'd0);
        applyStimulus(1'b1, 3'd0);
        checkOutput("idleLoad0", 5'b00000, 8'd0);
        applyStimulus(1'b1, 3'd0);
        checkOutput("acqRepeat", 5'b00010, 8'd0);
        applyStimulus(1'b1, 3'd7);
        checkOutput("acq7", 5'b00010, 8'd0);
        applyStimulus(1'b1, 3'd1);
        checkOutput("acqUpAfter7", 5'b00000, 8'd0);

        // Legal sweep from reset
        resetDut();
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b1, seqA[i]);
            eSw = (i == 12) ? 8'd1 : 8'd0;
            checkOutput($sformatf("sweep[%0d]", i), expA[i], eSw);
        end

        // Illegal value while locked in UP at prev=4
        applyStimulus(1'b1, 3'd3);
        checkOutput("up3", 5'b00001, 8'd1);
        applyStimulus(1'b1, 3'd4);
        checkOutput("up4", 5'b00001, 8'd1);
        applyStimulus(1'b1, 3'd7);
        checkOutput("ill7", 5'b00010, 8'd1);
        applyStimulus(1'b0, 3'd7);
        checkOutput("errCleared", 5'b00000, 8'd1);
        applyStimulus(1'b1, 3'd5);
        checkOutput("prevKept4", 5'b00000, 8'd1);
        applyStimulus(1'b1, 3'd6);
        checkOutput("relock6", 5'b00000, 8'd1);
        applyStimulus(1'b1, 3'd5);
        checkOutput("acqPeak", 5'b11001, 8'd1);

        // Stall while locked, then relock after three legal steps
        applyStimulus(1'b1, 3'd4);
        checkOutput("dn4", 5'b10001, 8'd1);
        applyStimulus(1'b1, 3'd3);
        checkOutput("dn3", 5'b10001, 8'd1);
        applyStimulus(1'b1, 3'd3);
        checkOutput("stall", 5'b00010, 8'd1);
        applyStimulus(1'b1, 3'd4);
        checkOutput("stall4", 5'b00000, 8'd1);
        applyStimulus(1'b1, 3'd5);
        checkOutput("stall5", 5'b00000, 8'd1);
        applyStimulus(1'b1, 3'd6);
        checkOutput("stall6Lock", 5'b00001, 8'd1);
        applyStimulus(1'b1, 3'd5);
        checkOutput("stallPeak", 5'b11001, 8'd1);

        // Legal sweep with qualifier gaps carrying garbage
        resetDut();
        lastExp = 5'b00000;
        lastSw  = 8'd0;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b0, 3'($urandom_range(0, 7)));
            checkOutput($sformatf("gap[%0d]", i), {lastExp[4], 3'b000, lastExp[0]}, lastSw);
            applyStimulus(1'b1, seqA[i]);
            eSw = (i == 12) ? 8'd1 : 8'd0;
            checkOutput($sformatf("gapSweep[%0d]", i), expA[i], eSw);
            lastExp = expA[i];
            lastSw  = eSw;
        end

        // 255 more full sweeps wrap sweep_cnt back to zero
        for (int i = 0; i < 255; i++) begin
            for (int j = 0; j < 10; j++) begin
                applyStimulus(1'b1, wrapSeq[j]);
            end
            if (i == 253) begin
                checkOutput("sweep255", 5'b00101, 8'd255);
            end
        end
        checkOutput("sweepWrap", 5'b00101, 8'd0);

        // Asynchronous reset between clock edges
        applyStimulus(1'b1, 3'd3);
        applyStimulus(1'b1, 3'd4);
        checkOutput("preRst", 5'b00001, 8'd0);
        #2;
        bus.cnt_vld = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("asyncRst", 5'b00000, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 3'd3);
        checkOutput("postRstIdle", 5'b00000, 8'd0);
        applyStimulus(1'b1, 3'd2);
        checkOutput("postRstDown", 5'b10000, 8'd0);

`ifdef BOUNCE_MON_ERR_CNT_EN
        // Saturating error counter
        resetDut();
        checkErrCnt("errCntReset", 8'd0, 1'b0);
        repeat (100) applyStimulus(1'b1, 3'd7);
        checkErrCnt("errCnt100", 8'd100, 1'b1);
        repeat (200) applyStimulus(1'b1, 3'd7);
        checkErrCnt("errCntSat", 8'd255, 1'b1);
        applyStimulus(1'b0, 3'd0);
        checkErrCnt("errCntHold", 8'd255, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
